// File: rtl/resdmac_top_if.sv
// CPU-side and peripheral-port bus of the SDMAC replacement. Each tristate line is
// split into input, output value and drive enable so the board-level buffers stay outside.
interface resdmac_top_if;
    logic        cs_n;
    logic        as_n;
    logic        ds_n;
    logic        r_w;
    logic [4:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        data_drv;
    logic [1:0]  dsack_n;
    logic        dsack_drv;
    logic [7:0]  pd_in;
    logic [7:0]  pd_out;
    logic        pd_drv;
    logic        ior_n;
    logic        iow_n;
    logic        css_n;

    modport slave (
        input  cs_n, as_n, ds_n, r_w, addr, data_in, pd_in,
        output data_out, data_drv, dsack_n, dsack_drv, pd_out, pd_drv, ior_n, iow_n, css_n
    );

    modport master (
        output cs_n, as_n, ds_n, r_w, addr, data_in, pd_in,
        input  data_out, data_drv, dsack_n, dsack_drv, pd_out, pd_drv, ior_n, iow_n, css_n
    );
endinterface

// File: rtl/resdmac_top.sv
// Amiga 3000 SDMAC replacement: register file slave at $00DD0000 plus a CPU bridge to
// the WD33C93A. No bus-master engine; DMA start/stop only toggle the activity flag.
module resdmac_top (
    input  logic clk,
    input  logic rst_n,
    resdmac_top_if.slave bus,
    input  logic sterm_n_i,
    input  logic berr_n_i,
    input  logic bg_n_i,
    input  logic dreq_n_i,
    input  logic inta_i,
    output logic int_n_o,
    output logic int_oe_o,
    output logic siz1_o,
    output logic br_n_o,
    output logic br_oe_o,
    output logic bgack_n_o,
    output logic bgack_oe_o,
    output logic dmaen_n_o,
    output logic dack_n_o,
    output logic led_rd_n_o,
    output logic led_wr_n_o,
    output logic led_dma_n_o,
    output logic own_n_o,
    output logic data_oe_n_o,
    output logic pdata_oe_n_o
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_REG_ACK, ST_SCSI_WAIT, ST_SCSI_ACK
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  wait_q, wait_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rw_q;
    logic [4:0]  addr_q;
    logic [1:0]  dawr_q;
    logic [23:0] wtc_q;
    logic [8:0]  cntr_q;
    logic [31:2] acr_q;
    logic        dma_act_q;
    logic        acc_stb;
    logic        cycle_start;
    logic        int_act;
    logic [31:0] reg_rdata;
    logic        unused_sigs;

    // DAWR is write-only and has nothing to steer without a DMA engine.
    assign unused_sigs = &{sterm_n_i, berr_n_i, bg_n_i, dreq_n_i, dawr_q};

    assign cycle_start = !bus.cs_n && !bus.as_n && !bus.ds_n;
    assign int_act     = inta_i && cntr_q[2];

    always_comb begin
        reg_rdata = 32'd0;
        case (addr_q)
            5'd1:    reg_rdata = {8'd0, wtc_q};
            5'd2:    reg_rdata = {23'd0, cntr_q};
            5'd3:    reg_rdata = {acr_q, 2'b00};
            5'd7:    reg_rdata = {23'd0, int_act, inta_i, inta_i, 1'b0, int_act, 3'd0, 1'b1};
            default: reg_rdata = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
        acc_stb = 1'b0;
        case (state_q)
            ST_IDLE: if (cycle_start) state_d = ST_START;
            ST_START: begin
                if (bus.as_n) begin
                    state_d = ST_IDLE;
                end else if (addr_q[4]) begin
                    state_d = ST_SCSI_WAIT;
                    wait_d  = 2'd0;
                end else begin
                    state_d = ST_REG_ACK;
                    acc_stb = 1'b1;
                    rdata_d = reg_rdata;
                end
            end
            // Three extra clocks give the WD33C93A its access time before DSACK.
            ST_SCSI_WAIT: begin
                if (bus.as_n) begin
                    state_d = ST_IDLE;
                end else if (wait_q == 2'd2) begin
                    state_d = ST_SCSI_ACK;
                    rdata_d = {4{bus.pd_in}};
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            ST_REG_ACK, ST_SCSI_ACK: if (bus.as_n) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wait_q    <= 2'd0;
            rdata_q   <= 32'd0;
            rw_q      <= 1'b0;
            addr_q    <= 5'd0;
            dawr_q    <= 2'd0;
            wtc_q     <= 24'd0;
            cntr_q    <= 9'd0;
            acr_q     <= 30'd0;
            dma_act_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
            if (state_q == ST_IDLE && cycle_start) begin
                rw_q   <= bus.r_w;
                addr_q <= bus.addr;
            end
            if (acc_stb) begin
                if (addr_q == 5'd4)  dma_act_q <= 1'b1;
                if (addr_q == 5'd15) dma_act_q <= 1'b0;
                if (!rw_q) begin
                    case (addr_q)
                        5'd0:    dawr_q <= bus.data_in[1:0];
                        5'd1:    wtc_q  <= bus.data_in[23:0];
                        5'd2:    cntr_q <= bus.data_in[8:0];
                        5'd3:    acr_q  <= bus.data_in[31:2];
                        default: ;
                    endcase
                end
            end
        end
    end

    logic reg_ack, scsi_act, ack, active;
    assign reg_ack  = (state_q == ST_REG_ACK);
    assign scsi_act = (state_q == ST_SCSI_WAIT) || (state_q == ST_SCSI_ACK);
    assign ack      = reg_ack || (state_q == ST_SCSI_ACK);
    assign active   = (state_q != ST_IDLE);

    assign bus.dsack_drv = ack;
    assign bus.dsack_n   = ack ? 2'b00 : 2'b11;
    assign bus.data_drv  = ack && rw_q;
    assign bus.data_out  = rdata_q;
    assign bus.css_n     = !scsi_act;
    assign bus.ior_n     = !(scsi_act && rw_q);
    assign bus.iow_n     = !(scsi_act && !rw_q);
    assign bus.pd_drv    = scsi_act && !rw_q;
    assign bus.pd_out    = bus.data_in[7:0];

    assign data_oe_n_o  = !((reg_ack && rw_q) || scsi_act);
    assign pdata_oe_n_o = !scsi_act;
    assign led_rd_n_o   = !(active && rw_q);
    assign led_wr_n_o   = !(active && !rw_q);
    assign led_dma_n_o  = !dma_act_q;
    assign int_oe_o     = int_act;
    assign int_n_o      = !int_act;

    assign siz1_o     = 1'b0;
    assign br_n_o     = 1'b1;
    assign br_oe_o    = 1'b0;
    assign bgack_n_o  = 1'b1;
    assign bgack_oe_o = 1'b0;
    assign dmaen_n_o  = 1'b1;
    assign dack_n_o   = 1'b1;
    assign own_n_o    = 1'b1;
endmodule

// File: tb/tb_resdmac_top.sv
// Self-checking bench for resdmac_top: randomized CPU cycles checked against a
// behavioural model of the register map and the SCSI bridge timing.
module tb_resdmac_top;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic inta = 1'b0;
    logic int_n, int_oe, siz1, br_n, br_oe, bgack_n, bgack_oe, dmaen_n, dack_n;
    logic led_rd_n, led_wr_n, led_dma_n, own_n, data_oe_n, pdata_oe_n;

    resdmac_top_if bus ();

    resdmac_top dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .sterm_n_i(1'b1), .berr_n_i(1'b1), .bg_n_i(1'b1), .dreq_n_i(1'b1),
        .inta_i(inta), .int_n_o(int_n), .int_oe_o(int_oe), .siz1_o(siz1),
        .br_n_o(br_n), .br_oe_o(br_oe), .bgack_n_o(bgack_n), .bgack_oe_o(bgack_oe),
        .dmaen_n_o(dmaen_n), .dack_n_o(dack_n), .led_rd_n_o(led_rd_n),
        .led_wr_n_o(led_wr_n), .led_dma_n_o(led_dma_n), .own_n_o(own_n),
        .data_oe_n_o(data_oe_n), .pdata_oe_n_o(pdata_oe_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the register file
    logic [1:0]  m_dawr;
    logic [23:0] m_wtc;
    logic [8:0]  m_cntr;
    logic [31:0] m_acr;
    logic        m_dma;

    task automatic model_reset();
        m_dawr = '0; m_wtc = '0; m_cntr = '0; m_acr = '0; m_dma = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input int off, input logic ia);
        logic [31:0] v;
        v = 32'd0;
        case (off)
            'h04: v = {8'h00, m_wtc};
            'h08: v = {23'd0, m_cntr};
            'h0C: v = m_acr & 32'hFFFF_FFFC;
            'h1C: begin
                v = 32'h1;
                if (ia) v = v | 32'hC0;
                if (ia && m_cntr[2]) v = v | 32'h110;
            end
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    task automatic model_access(input int off, input logic rw, input logic [31:0] wd);
        if (off == 'h10) m_dma = 1'b1;
        if (off == 'h3C) m_dma = 1'b0;
        if (!rw) begin
            case (off)
                'h00: m_dawr = wd[1:0];
                'h04: m_wtc  = wd[23:0];
                'h08: m_cntr = wd[8:0];
                'h0C: m_acr  = wd;
                default: ;
            endcase
        end
    endtask

    // Observations of the most recent bus cycle
    int          obs_lat;
    logic [31:0] obs_data;
    logic        obs_data_drv, obs_data_oe_n;
    logic        obs_css_n, obs_ior_n, obs_iow_n, obs_pd_drv, obs_pdata_oe_n, obs_strobe_oe_n;
    logic [7:0]  obs_pd;
    logic        obs_led_rd, obs_led_wr, obs_rel;

    // Starts at a falling edge, ends at a falling edge after one AS-high rising edge.
    task automatic bus_cycle(input logic rw, input logic [4:0] a, input logic [31:0] wd,
                             input logic [7:0] pd);
        bus.r_w = rw; bus.addr = a; bus.data_in = wd; bus.pd_in = pd;
        bus.cs_n = 1'b0; bus.as_n = 1'b0; bus.ds_n = 1'b0;
        obs_lat = -1;
        obs_data = 32'd0; obs_data_drv = 1'b0; obs_data_oe_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 2) begin
                obs_css_n = bus.css_n; obs_ior_n = bus.ior_n; obs_iow_n = bus.iow_n;
                obs_pd_drv = bus.pd_drv; obs_pd = bus.pd_out;
                obs_pdata_oe_n = pdata_oe_n; obs_strobe_oe_n = data_oe_n;
                obs_led_rd = led_rd_n; obs_led_wr = led_wr_n;
            end
            if (bus.dsack_drv) begin
                obs_lat = k; obs_data = bus.data_out;
                obs_data_drv = bus.data_drv; obs_data_oe_n = data_oe_n;
                break;
            end
        end
        bus.as_n = 1'b1; bus.ds_n = 1'b1; bus.cs_n = 1'b1;
        @(negedge clk);
        obs_rel = !bus.dsack_drv && !bus.data_drv && bus.css_n && bus.ior_n && bus.iow_n &&
                  !bus.pd_drv && data_oe_n && pdata_oe_n && led_rd_n && led_wr_n;
        $display("txn %s addr=%02h off=%02h wd=%08h pd=%02h lat=%0d rd=%08h",
                 rw ? "RD" : "WR", a, {a, 2'b00}, wd, pd, obs_lat, obs_data);
    endtask

    task automatic test_reset();
        checks++; if (bus.dsack_drv !== 1'b0 || bus.dsack_n !== 2'b11) begin errors++;
            $display("FAIL reset_dsack: got drv=%b val=%b want 0/11", bus.dsack_drv, bus.dsack_n); end
        checks++; if (bus.data_drv !== 1'b0) begin errors++;
            $display("FAIL reset_data: got drv=%b want 0", bus.data_drv); end
        checks++; if (own_n !== 1'b1 || siz1 !== 1'b0) begin errors++;
            $display("FAIL reset_own_siz: got own=%b siz1=%b want 1/0", own_n, siz1); end
        checks++; if ({led_rd_n, led_wr_n, led_dma_n} !== 3'b111) begin errors++;
            $display("FAIL reset_leds: got %b want 111", {led_rd_n, led_wr_n, led_dma_n}); end
        checks++; if ({bus.css_n, bus.ior_n, bus.iow_n, data_oe_n, pdata_oe_n} !== 5'b11111) begin errors++;
            $display("FAIL reset_strobes: got %b want 11111",
                     {bus.css_n, bus.ior_n, bus.iow_n, data_oe_n, pdata_oe_n}); end
        checks++; if ({int_oe, br_oe, bgack_oe, dmaen_n, dack_n} !== 5'b00011) begin errors++;
            $display("FAIL reset_master: got %b want 00011", {int_oe, br_oe, bgack_oe, dmaen_n, dack_n}); end
        @(negedge clk); rst_n = 1'b1;
        bus_cycle(1'b1, 5'd2, 32'd0, 8'd0);
        checks++; if (obs_lat != 2 || obs_data !== 32'd0) begin errors++;
            $display("FAIL reset_cntr: got lat=%0d data=%08h want 2/00000000", obs_lat, obs_data); end
    endtask

    task automatic test_reset_abort();
        bus.r_w = 1'b1; bus.addr = 5'h10; bus.pd_in = 8'hA5;
        bus.cs_n = 1'b0; bus.as_n = 1'b0; bus.ds_n = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++; if (bus.css_n !== 1'b0 || bus.ior_n !== 1'b0) begin errors++;
            $display("FAIL abort_pre: got css=%b ior=%b want 0/0", bus.css_n, bus.ior_n); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.css_n !== 1'b1 || bus.ior_n !== 1'b1 || led_rd_n !== 1'b1) begin errors++;
            $display("FAIL abort_async: got css=%b ior=%b led_rd=%b want 1/1/1",
                     bus.css_n, bus.ior_n, led_rd_n); end
        bus.cs_n = 1'b1; bus.as_n = 1'b1; bus.ds_n = 1'b1;
        model_reset();
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_cntr_rw();
        bus_cycle(1'b0, 5'd2, 32'h0000_0006, 8'd0);
        model_access('h08, 1'b0, 32'h6);
        checks++; if (obs_lat != 2) begin errors++;
            $display("FAIL cntr_wr_lat: got %0d want 2", obs_lat); end
        checks++; if (obs_led_wr !== 1'b0 || obs_led_rd !== 1'b1) begin errors++;
            $display("FAIL cntr_wr_led: got wr=%b rd=%b want 0/1", obs_led_wr, obs_led_rd); end
        checks++; if (obs_rel !== 1'b1) begin errors++;
            $display("FAIL cntr_wr_release: got %b want 1", obs_rel); end
        bus_cycle(1'b1, 5'd2, 32'd0, 8'd0);
        checks++; if (obs_data !== 32'h6 || obs_data_drv !== 1'b1 || obs_data_oe_n !== 1'b0) begin errors++;
            $display("FAIL cntr_rd: got data=%08h drv=%b oe_n=%b want 00000006/1/0",
                     obs_data, obs_data_drv, obs_data_oe_n); end
        checks++; if (obs_led_rd !== 1'b0 || obs_lat != 2) begin errors++;
            $display("FAIL cntr_rd_ack: got led_rd=%b lat=%0d want 0/2", obs_led_rd, obs_lat); end
    endtask

    task automatic test_interrupt();
        bus_cycle(1'b0, 5'd2, 32'h4, 8'd0);
        model_access('h08, 1'b0, 32'h4);
        inta = 1'b1; #1;
        checks++; if (int_oe !== 1'b1 || int_n !== 1'b0) begin errors++;
            $display("FAIL int_on: got oe=%b n=%b want 1/0", int_oe, int_n); end
        bus_cycle(1'b1, 5'd7, 32'd0, 8'd0);
        checks++; if (obs_data !== 32'h0000_01D1) begin errors++;
            $display("FAIL istr_on: got %08h want 000001D1", obs_data); end
        inta = 1'b0; #1;
        checks++; if (int_oe !== 1'b0) begin errors++;
            $display("FAIL int_off: got oe=%b want 0", int_oe); end
        bus_cycle(1'b1, 5'd7, 32'd0, 8'd0);
        checks++; if (obs_data !== 32'h0000_0001) begin errors++;
            $display("FAIL istr_off: got %08h want 00000001", obs_data); end
    endtask

    task automatic test_scsi(input logic rw, input logic [4:0] a, input logic [31:0] wd,
                             input logic [7:0] pd);
        bus_cycle(rw, a, wd, pd);
        checks++; if (obs_lat != 5) begin errors++;
            $display("FAIL scsi_lat: got %0d want 5", obs_lat); end
        checks++; if (obs_css_n !== 1'b0 || obs_pdata_oe_n !== 1'b0 || obs_strobe_oe_n !== 1'b0) begin errors++;
            $display("FAIL scsi_sel: got css=%b pdoe=%b doe=%b want 0/0/0",
                     obs_css_n, obs_pdata_oe_n, obs_strobe_oe_n); end
        checks++; if (obs_ior_n !== !rw || obs_iow_n !== rw) begin errors++;
            $display("FAIL scsi_strobe: got ior=%b iow=%b want %b/%b", obs_ior_n, obs_iow_n, !rw, rw); end
        if (rw) begin
            checks++; if (obs_data !== {4{pd}} || obs_data_drv !== 1'b1 || obs_pd_drv !== 1'b0) begin errors++;
                $display("FAIL scsi_rd: got data=%08h drv=%b pddrv=%b want %08h/1/0",
                         obs_data, obs_data_drv, obs_pd_drv, {4{pd}}); end
        end else begin
            checks++; if (obs_pd !== wd[7:0] || obs_pd_drv !== 1'b1 || obs_data_drv !== 1'b0) begin errors++;
                $display("FAIL scsi_wr: got pd=%02h pddrv=%b ddrv=%b want %02h/1/0",
                         obs_pd, obs_pd_drv, obs_data_drv, wd[7:0]); end
        end
        checks++; if (obs_rel !== 1'b1) begin errors++;
            $display("FAIL scsi_release: got %b want 1", obs_rel); end
    endtask

    task automatic test_dma();
        bus_cycle(1'b1, 5'd4, 32'd0, 8'd0);
        checks++; if (led_dma_n !== 1'b0) begin errors++;
            $display("FAIL dma_start: got led_dma=%b want 0", led_dma_n); end
        bus_cycle(1'b1, 5'd15, 32'd0, 8'd0);
        checks++; if (led_dma_n !== 1'b1) begin errors++;
            $display("FAIL dma_stop: got led_dma=%b want 1", led_dma_n); end
        m_dma = 1'b0;
    endtask

    task automatic test_cs_ignored();
        logic quiet;
        quiet = 1'b1;
        bus.cs_n = 1'b1; bus.as_n = 1'b0; bus.ds_n = 1'b0; bus.r_w = 1'b1; bus.addr = 5'd2;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.dsack_drv || bus.data_drv || !bus.css_n || !led_rd_n) quiet = 1'b0;
        end
        bus.as_n = 1'b1; bus.ds_n = 1'b1;
        @(negedge clk);
        checks++; if (quiet !== 1'b1) begin errors++;
            $display("FAIL cs_ignored: got quiet=%b want 1", quiet); end
    endtask

    task automatic test_random_regs();
        logic [4:0]  a;
        logic        rw;
        logic [31:0] wd, exp;
        int          off;
        for (int i = 0; i < 40; i++) begin
            a    = 5'($urandom_range(0, 15));
            rw   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            inta = 1'($urandom_range(0, 1));
            off  = int'(a) * 4;
            exp  = model_read(off, inta);
            bus_cycle(rw, a, wd, 8'h00);
            model_access(off, rw, wd);
            checks++; if (obs_lat != 2) begin errors++;
                $display("FAIL rand_lat[%0d]: got %0d want 2", i, obs_lat); end
            if (rw) begin
                checks++; if (obs_data !== exp) begin errors++;
                    $display("FAIL rand_rd[%0d] off=%02h: got %08h want %08h", i, off, obs_data, exp); end
            end
            checks++; if (led_dma_n !== !m_dma || int_oe !== (inta & m_cntr[2])) begin errors++;
                $display("FAIL rand_state[%0d]: got led_dma=%b int_oe=%b want %b/%b",
                         i, led_dma_n, int_oe, !m_dma, inta & m_cntr[2]); end
        end
        inta = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd;
        wd = $urandom;
        bus_cycle(1'b0, 5'd3, wd, 8'd0);
        model_access('h0C, 1'b0, wd);
        bus_cycle(1'b1, 5'd3, 32'd0, 8'd0);
        checks++; if (obs_lat != 2 || obs_data !== model_read('h0C, 1'b0)) begin errors++;
            $display("FAIL b2b_acr: got lat=%0d data=%08h want 2/%08h", obs_lat, obs_data,
                     model_read('h0C, 1'b0)); end
    endtask

    initial begin
        bus.cs_n = 1'b1; bus.as_n = 1'b1; bus.ds_n = 1'b1; bus.r_w = 1'b1;
        bus.addr = 5'd0; bus.data_in = 32'd0; bus.pd_in = 8'd0;
        model_reset();
        #23;
        test_reset();
        test_cntr_rw();
        test_interrupt();
        test_scsi(1'b0, 5'h10, 32'h0000_005A, 8'h00);
        test_scsi(1'b1, 5'h10, 32'h0000_0000, 8'h3C);
        for (int i = 0; i < 6; i++)
            test_scsi(1'($urandom_range(0, 1)), 5'(16 + $urandom_range(0, 15)), $urandom,
                      8'($urandom_range(0, 255)));
        test_dma();
        test_cs_ignored();
        test_random_regs();
        test_back_to_back();
        test_reset_abort();
        bus_cycle(1'b1, 5'd2, 32'd0, 8'd0);
        checks++; if (obs_lat != 2 || obs_data !== 32'd0) begin errors++;
            $display("FAIL post_abort_cntr: got lat=%0d data=%08h want 2/00000000", obs_lat, obs_data); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
